jtopl_serial_tx: RTL and testbench
==================================

# jtopl_serial_tx

Serial DAC transmitter at the output end of the operator accumulator. Takes each finished mixed sample (the saturated `snd` word produced once per sample period), converts it to the 3-bit-exponent / 10-bit-mantissa floating-point format used by the external YM3014-style DAC, and shifts it out LSB-first in fixed 16-slot frames with a latch strobe. Double-buffered so that sample production and frame transmission run independently.

## Interface
- `INW`, 16: linear input width, legal range 10..16; max exponent EMAX = INW-9
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cen`  in  1  bit-slot clock enable; one slot advances per `cen` cycle
- `snd`  in  INW  signed linear sample
- `snd_valid`  in  1  one-`clk` pulse: `snd` valid, write holding register
- `sdo`  out  1  serial data, changes only on `cen` cycles
- `sy`  out  1  DAC latch strobe, high during slot 15 only
- `slot`  out  4  current slot index, 0..15
- `overrun`  out  1  sticky: holding register overwritten before consumed
- `ovr_clr`  in  1  synchronous clear of `overrun`

## Operation
- Holding register (`hold`, `hold_full`): `snd_valid` writes `snd`, sets `hold_full`. If `hold_full` already set and not consumed this cycle: data overwritten, `overrun` set.
- Frame start (`cen` while `slot`==15, next slot 0): if `hold_full`, convert `hold` into shift register, clear `hold_full`; else reconvert last transmitted sample (DAC holds level).
- Simultaneous frame-start consume and `snd_valid`: consume takes old `hold`; new value written, `hold_full` stays 1; no overrun.
- Conversion: e = smallest value in 1..EMAX such that `snd >>> (e-1)` fits 10-bit signed (-512..511); m = `snd >>> (e-1)` truncated to 10 bits.
- Frame layout, slot n carries: 0-2 zero, 3-12 m[n-3] (m LSB in slot 3), 13-15 e[n-13].
- `ovr_clr` and `overrun` set in same cycle: set wins.
- States: RUN only after reset; slot counter 0..15 wraps continuously; no idle state.

## Timing
- Reset: `sdo`=0, `sy`=0, `slot`=0, `hold_full`=0, `hold`=0, last sample=0, `overrun`=0. First frame after reset transmits m=0, e=1.
- `sdo`/`sy`/`slot` registered; update on the `cen` cycle entering the slot.
- Latency: `snd_valid` to first `sdo` bit of that sample = wait until next frame start (0..16 `cen` periods) + 1 `clk`.
- Mid-frame `rst_n` assertion: all state cleared immediately; partial frame abandoned; restart from slot 0 with the zero sample.
- `cen` stuck low: outputs frozen; `snd_valid` still accepted (overrun rules apply).

## Configuration
- `JTOPL_SERIAL_ROUND_EN` defined: mantissa rounded (add 1 at bit e-2 before shift, e>1); result exceeding 511 saturates to 511, below -512 to -512; exponent unchanged.
- Undefined: truncation (arithmetic shift) as above.

## Structure
- Package `jtopl_serial_pkg`: FRAME_LEN=16, MANT_W=10, EXP_W=3, slot constants SLOT_MANT0=3, SLOT_EXP0=13, SLOT_SY=15.
- Sub-module `jtopl_lin2fp`: combinational linear-to-float converter (priority detection of e, shift, optional rounding); instantiated once at frame-start path.

## Test plan
- Reset, `cen` every 4th clk, no samples -> frames repeat m=0, e=1: `sdo` bits all 0 except slot 13; `sy` high only slot 15.
- `snd`=16'h0100 -> m=256, e=1: `sdo`=1 in slot 11 and slot 13 only.
- `snd`=16'h1000 -> e=5, m=256; `snd`=16'h8000 -> e=7, m=10'h200; `snd`=16'h7FFF -> e=7, m=511.
- With `JTOPL_SERIAL_ROUND_EN`: `snd`=16'h7FFF -> m=511 (saturated), e=7; `snd`=16'h0003 -> unchanged m=3, e=1.
- Two `snd_valid` pulses in one frame -> second sample transmitted next frame, `overrun`=1 until `ovr_clr`; pulse coinciding with frame start -> no overrun.
- `rst_n` low at slot 8 -> `slot`=0, `sdo`=0, `hold_full`=0 immediately; next frames transmit zero sample.

Source files
------------

// File: rtl/jtopl_serial_pkg.sv
// rtl/jtopl_serial_pkg.sv - frame layout constants and float sample type for the serial DAC transmitter
package jtopl_serial_pkg;
  localparam int FRAME_LEN  = 16;
  localparam int MANT_W     = 10;
  localparam int EXP_W      = 3;
  localparam int SLOT_MANT0 = 3;
  localparam int SLOT_EXP0  = 13;
  localparam int SLOT_SY    = 15;

  typedef struct packed {
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
  } fp_t;

  // Zero sample as transmitted after reset: m=0, e=1.
  localparam logic [FRAME_LEN-1:0] FRAME_ZERO = {3'd1, 10'd0, 3'd0};

  function automatic logic [FRAME_LEN-1:0] pack_frame(fp_t fp);
    logic [FRAME_LEN-1:0] f;
    f = '0;
    f[SLOT_MANT0 +: MANT_W] = fp.m;
    f[SLOT_EXP0 +: EXP_W]   = fp.e;
    return f;
  endfunction
endpackage

// File: rtl/jtopl_lin2fp.sv
// rtl/jtopl_lin2fp.sv - combinational linear to 3-bit exponent / 10-bit mantissa converter
// Optional rounding of the mantissa when JTOPL_SERIAL_ROUND_EN is defined.
module jtopl_lin2fp
  import jtopl_serial_pkg::*;
#(
  parameter int INW = 16
) (
  input  logic [INW-1:0] lin,
  output fp_t            fp
);
  localparam int EMAX = INW - 9;

  logic signed [INW:0] ext;
  logic signed [INW:0] shifted;
  logic                fits;
  int                  e;
`ifdef JTOPL_SERIAL_ROUND_EN
  logic signed [INW:0] rnd;
`endif

  always_comb begin
    ext     = {lin[INW-1], lin};
    e       = EMAX;
    shifted = '0;
    // Scan downwards so the last hit is the smallest exponent that fits.
    for (int k = EMAX; k >= 1; k--) begin
      shifted = ext >>> (k - 1);
      if ((&shifted[INW:MANT_W-1]) || !(|shifted[INW:MANT_W-1])) e = k;
    end
    shifted = ext >>> (e - 1);
`ifdef JTOPL_SERIAL_ROUND_EN
    rnd = ext;
    if (e > 1) begin
      rnd     = ext + $signed((INW+1)'(1) << (e - 2));
      shifted = rnd >>> (e - 1);
    end
`endif
    fits = (&shifted[INW:MANT_W-1]) || !(|shifted[INW:MANT_W-1]);
    fp.e = EXP_W'(e);
    if (fits) fp.m = shifted[MANT_W-1:0];
    else      fp.m = shifted[INW] ? 10'h200 : 10'h1ff;
  end
endmodule

// File: rtl/jtopl_serial_tx.sv
// rtl/jtopl_serial_tx.sv - double-buffered serial DAC transmitter, 16-slot LSB-first frames with latch strobe
// JTOPL_SERIAL_ROUND_EN selects rounded instead of truncated mantissa in the converter.
module jtopl_serial_tx
  import jtopl_serial_pkg::*;
#(
  parameter int INW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic [INW-1:0] snd,
  input  logic           snd_valid,
  output logic           sdo,
  output logic           sy,
  output logic [3:0]     slot,
  output logic           overrun,
  input  logic           ovr_clr
);
  logic [INW-1:0]       hold;
  logic [INW-1:0]       last;
  logic                 hold_full;
  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] frame_next;
  logic [INW-1:0]       src;
  logic [3:0]           next_slot;
  logic                 frame_start;
  logic                 consume;
  fp_t                  conv;

  assign frame_start = cen && (slot == 4'(SLOT_SY));
  assign consume     = frame_start && hold_full;
  // With no fresh sample, the last one is resent so the DAC keeps its level.
  assign src         = hold_full ? hold : last;
  assign next_slot   = slot + 4'd1;
  assign frame_next  = pack_frame(conv);

  jtopl_lin2fp #(.INW(INW)) u_lin2fp (
    .lin (src),
    .fp  (conv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      sdo       <= 1'b0;
      sy        <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      last      <= '0;
      frame     <= FRAME_ZERO;
      overrun   <= 1'b0;
    end else begin
      if (cen) begin
        slot <= next_slot;
        sy   <= (next_slot == 4'(SLOT_SY));
        if (frame_start) begin
          frame <= frame_next;
          last  <= src;
          sdo   <= frame_next[0];
        end else begin
          sdo   <= frame[next_slot];
        end
      end
      // A write racing the frame-start consume is not an overrun.
      if (snd_valid) begin
        hold      <= snd;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
      if (snd_valid && hold_full && !consume) overrun <= 1'b1;
      else if (ovr_clr)                       overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jtopl_serial_tx.sv
// tb/tb_jtopl_serial_tx.sv - scoreboard bench for jtopl_serial_tx
module tb_jtopl_serial_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        snd_valid = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [15:0] snd = '0;
  logic        sdo, sy, overrun;
  logic [3:0]  slot;

  jtopl_serial_tx #(.INW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .snd       (snd),
    .snd_valid (snd_valid),
    .sdo       (sdo),
    .sy        (sy),
    .slot      (slot),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_frame(input logic [15:0] s);
    int v, e, m;
    e = 7;
    for (int k = 7; k >= 1; k--) begin
      v = $signed(s) >>> (k - 1);
      if (v >= -512 && v <= 511) e = k;
    end
    v = $signed(s) >>> (e - 1);
`ifdef JTOPL_SERIAL_ROUND_EN
    if (e > 1) begin
      v = (int'($signed(s)) + (1 << (e - 2))) >>> (e - 1);
      if (v > 511) v = 511;
      if (v < -512) v = -512;
    end
`endif
    m = v & 32'h3ff;
    return {e[2:0], m[9:0], 3'b000};
  endfunction

  bit cen_on = 1'b1;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      cen = cen_on && (cnt % 4 == 0);
    end
  end

  // Reference model and frame scoreboard; sampled mid-cycle.
  int          m_slot;
  logic        m_full, m_ovr, m_consumed, m_set, cen_prev, sy_bad;
  logic [15:0] m_hold, m_last, m_src, bits;
  logic [15:0] exp_q[$];
  int          frames;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot = 0; m_full = 0; m_ovr = 0; m_hold = '0; m_last = '0;
      exp_q.delete();
      exp_q.push_back(exp_frame(16'h0000));
      bits = '0; bits[0] = sdo; sy_bad = 0; cen_prev = 0;
    end else begin
      if (cen_prev) begin
        check("slot", 32'(slot), 32'(m_slot));
        check("overrun", 32'(overrun), 32'(m_ovr));
        bits[m_slot] = sdo;
        if (sy !== (m_slot == 15)) sy_bad = 1;
        if (m_slot == 15) begin
          if (exp_q.size() == 0) check("exp_q_empty", 32'(exp_q.size()), 1);
          else check("frame", 32'(bits), 32'(exp_q.pop_front()));
          check("sy_slot15_only", 32'(sy_bad), 0);
          bits = '0; sy_bad = 0; frames++;
        end
      end
      m_consumed = 0;
      if (cen) begin
        if (m_slot == 15) begin
          m_src = m_full ? m_hold : m_last;
          m_consumed = m_full;
          m_last = m_src;
          exp_q.push_back(exp_frame(m_src));
        end
        m_slot = (m_slot + 1) % 16;
      end
      m_set = snd_valid && m_full && !m_consumed;
      if (snd_valid) begin m_hold = snd; m_full = 1; end
      else if (m_consumed) m_full = 0;
      if (m_set) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
      cen_prev = cen;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Return just before the posedge that enters slot s.
  task automatic wait_enter(input int s);
    bit hit;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (cen && m_slot == (s + 15) % 16) hit = 1;
    end
    if (!hit) check("wait_enter_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] v);
    snd = v;
    snd_valid = 1'b1;
    tick();
    snd_valid = 1'b0;
  endtask

  task automatic run_frames(input int n);
    repeat (n * 64) tick();
  endtask

  logic [15:0] vals[$];

  initial begin
    frames = 0;
    repeat (3) tick();
    check("rst_slot", 32'(slot), 0);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_sy", 32'(sy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_hold_full", 32'(dut.hold_full), 0);
    rst_n = 1'b1;
    run_frames(2);

    vals = '{16'h0100, 16'h1000, 16'h8000, 16'h7fff, 16'h0003, 16'hffff,
             16'hfe00, 16'h0200, 16'h0201, 16'hc123};
    vals.push_back(16'($urandom));
    vals.push_back(16'($urandom));
    foreach (vals[i]) begin
      wait_enter(1);
      send(vals[i]);
      run_frames(2);
    end

    wait_enter(2); send(16'h0040);
    wait_enter(6); send(16'h2345);
    check("ovr_set", 32'(overrun), 1);
    run_frames(2);
    check("ovr_sticky", 32'(overrun), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);

    wait_enter(2); send(16'h1111);
    wait_enter(6); ovr_clr = 1'b1; send(16'hf00d); ovr_clr = 1'b0;
    check("ovr_set_wins", 32'(overrun), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    run_frames(1);

    wait_enter(4); send(16'h0555);
    wait_enter(0); send(16'hfaaa);
    check("ovr_frame_start", 32'(overrun), 0);
    run_frames(2);

    wait_enter(5);
    cen_on = 1'b0;
    repeat (8) tick();
    send(16'h3000);
    repeat (20) tick();
    send(16'h0123);
    repeat (10) tick();
    check("frozen_slot", 32'(slot), 5);
    check("frozen_sy", 32'(sy), 0);
    check("ovr_stuck_cen", 32'(overrun), 1);
    cen_on = 1'b1;
    run_frames(3);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

    wait_enter(3); send(16'h4321);
    wait_enter(8); tick();
    check("pre_rst_hold_full", 32'(dut.hold_full), 1);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_slot", 32'(slot), 0);
    check("midrst_sdo", 32'(sdo), 0);
    check("midrst_hold_full", 32'(dut.hold_full), 0);
    tick(); tick();
    rst_n = 1'b1;
    run_frames(3);
    check("frames_seen", 32'(frames > 30), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
